data_memory_pipelined: RTL and testbench

Parametrised, byte-addressed, little-endian data memory for the pipeline's MEM stage. It is the successor to the fixed 16-bit, 1/2-byte data memory.
- Generalised data width, depth and access size (1/2/4… bytes).
- Zero or sign extension of narrow loads.
- Valid/ready request handshake with configurable read latency.
- Range-error reporting.
- Reset-triggered memory clear state machine.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_resp_pipe.sv | 93 +++++++++
 rtl/data_memory_pipelined.sv | 111 +++++++++++
 tb/tb_data_memory_pipelined.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic {ST_CLEAR, ST_READY} dmem_state_e;

  function automatic int unsigned size_bytes(logic [1:0] size);
    int unsigned n;
    unique case (size)
      SZ_BYTE:  n = 1;
      SZ_HALF:  n = 2;
      SZ_WORD:  n = 4;
      SZ_DWORD: n = 8;
      default:  n = 1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// Response delay line (1 or 2 stages); load extension happens on entry to the last stage.
module dmem_resp_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_error,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              out_valid,
  output logic              out_error,
  output logic [DATA_W-1:0] out_rdata
);

  localparam int unsigned NB = DATA_W / 8;

  function automatic logic [DATA_W-1:0] extend(logic [DATA_W-1:0] raw, logic [1:0] size,
                                               logic sgn);
    int unsigned       n;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] res;
    n   = size_bytes(size);
    res = raw;
    if (n < NB) begin
      sh   = raw >> (8 * n - 1);
      mask = {DATA_W{1'b1}} << (8 * n);
      res  = (sgn && sh[0]) ? (raw | mask) : (raw & ~mask);
    end
    return res;
  endfunction

  logic              last_valid;
  logic              last_error;
  logic [DATA_W-1:0] last_rdata;
  logic              valid_q;
  logic              error_q;
  logic [DATA_W-1:0] rdata_q;

  if (LATENCY == 2) begin : g_two_stage
    logic              s1_valid_q;
    logic              s1_error_q;
    logic              s1_signed_q;
    logic [1:0]        s1_size_q;
    logic [DATA_W-1:0] s1_rdata_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid_q  <= 1'b0;
        s1_error_q  <= 1'b0;
        s1_signed_q <= 1'b0;
        s1_size_q   <= '0;
        s1_rdata_q  <= '0;
      end else begin
        s1_valid_q  <= in_valid;
        s1_error_q  <= in_error;
        s1_signed_q <= in_signed;
        s1_size_q   <= in_size;
        s1_rdata_q  <= in_rdata;
      end
    end

    assign last_valid = s1_valid_q;
    assign last_error = s1_error_q;
    assign last_rdata = extend(s1_rdata_q, s1_size_q, s1_signed_q);
  end else begin : g_one_stage
    assign last_valid = in_valid;
    assign last_error = in_error;
    assign last_rdata = extend(in_rdata, in_size, in_signed);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= last_valid;
      error_q <= last_error;
      rdata_q <= last_rdata;
    end
  end

  assign out_valid = valid_q;
  assign out_error = error_q;
  assign out_rdata = rdata_q;

endmodule

// File: rtl/data_memory_pipelined.sv
// Byte-addressed little-endian data memory with reset clear and pipelined responses.
// Define DMEM_ALIGN_CHECK_EN to also reject accesses whose address is not a multiple of their size.
module data_memory_pipelined
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              init_done
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned ROWS  = DEPTH / NB;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  dmem_state_e       state_q;
  logic [ROW_W-1:0]  row_q;
  logic [7:0]        mem [DEPTH];

  logic              accept;
  logic              req_err;
  int unsigned       n_bytes;
  int unsigned       addr_int;
  logic [DATA_W-1:0] rd_raw;

  assign req_ready = (state_q == ST_READY);
  assign init_done = req_ready;
  assign accept    = req_valid && req_ready;

  // Range check is written as a subtraction so it cannot overflow for wide addresses.
  always_comb begin
    n_bytes  = size_bytes(req_size);
    addr_int = 32'(req_addr);
    req_err  = (n_bytes > NB) || (addr_int > DEPTH - n_bytes);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((addr_int & (n_bytes - 1)) != 0) begin
      req_err = 1'b1;
    end
`endif
  end

  always_comb begin
    rd_raw = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (k < n_bytes && !req_err) begin
        rd_raw[8*k +: 8] = mem[IDX_W'(addr_int + k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        for (int unsigned k = 0; k < NB; k++) begin
          mem[IDX_W'(32'(row_q) * NB + k)] <= 8'h00;
        end
      end else if (accept && req_write && !req_err) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (k < n_bytes) begin
            mem[IDX_W'(addr_int + k)] <= req_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      row_q   <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (32'(row_q) == ROWS - 1) begin
        state_q <= ST_READY;
      end
      row_q <= row_q + 1'b1;
    end
  end

  dmem_resp_pipe #(
    .DATA_W (DATA_W),
    .LATENCY(READ_LATENCY)
  ) u_resp_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept),
    .in_error (req_err),
    .in_size  (req_size),
    .in_signed(req_signed && !req_write && !req_err),
    .in_rdata (req_write ? '0 : rd_raw),
    .out_valid(resp_valid),
    .out_error(resp_error),
    .out_rdata(resp_rdata)
  );

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: latency-1 and latency-2 instances share one stimulus stream.
module tb_data_memory_pipelined;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int DEPTH        = 256;
  localparam int CLEAR_CYCLES = 128;
  localparam int NRAND        = 300;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        req_valid  = 1'b0;
  logic        req_write  = 1'b0;
  logic [1:0]  req_size   = 2'd0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr   = 16'h0;
  logic [15:0] req_wdata  = 16'h0;

  logic        req_ready1, resp_valid1, resp_error1, init_done1;
  logic [15:0] resp_rdata1;
  logic        req_ready2, resp_valid2, resp_error2, init_done2;
  logic [15:0] resp_rdata2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  data_memory_pipelined #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
    .resp_error(resp_error1), .init_done(init_done1)
  );

  data_memory_pipelined #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
    .resp_error(resp_error2), .init_done(init_done2)
  );

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
  endtask

  // Reference behaviour: byte-array memory, value assembled arithmetically.
  task automatic model_access(input logic w, input logic [1:0] sz, input logic sg, input int addr,
                              input logic [15:0] wd, output logic err, output logic [15:0] rd);
    int n;
    int val;
    n   = 1 << sz;
    err = (n > DATA_W / 8) || (addr + n > DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr % n != 0) err = 1'b1;
`endif
    rd = 16'h0;
    if (!err && w) begin
      for (int k = 0; k < n; k++) model_mem[addr + k] = wd[8*k +: 8];
    end else if (!err) begin
      val = 0;
      for (int k = 0; k < n; k++) val = val + (int'(model_mem[addr + k]) << (8 * k));
      if (sg && (8 * n < DATA_W) && model_mem[addr + n - 1][7]) val = val - (1 << (8 * n));
      rd = val[15:0];
    end
  endtask

  task automatic wait_init(output int f1, output int f2);
    f1 = -1;
    f2 = -1;
    for (int c = 1; c <= 400 && (f1 < 0 || f2 < 0); c++) begin
      @(negedge clk);
      if (f1 < 0 && init_done1 === 1'b1) f1 = c;
      if (f2 < 0 && init_done2 === 1'b1) f2 = c;
    end
  endtask

  // Single isolated transaction, checked on both instances at their own latency.
  task automatic xact(input string name, input logic w, input logic [1:0] sz, input logic sg,
                      input int addr, input logic [15:0] wd);
    logic        exp_err;
    logic [15:0] exp_rd;
    model_access(w, sz, sg, addr, wd, exp_err, exp_rd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr  = 16'(addr); req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (resp_valid1 !== 1'b1 || resp_error1 !== exp_err || resp_rdata1 !== exp_rd ||
        resp_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL %s lat1: got valid=%b err=%b rdata=%h lat2_valid=%b, want 1 %b %h lat2_valid=0",
               name, resp_valid1, resp_error1, resp_rdata1, resp_valid2, exp_err, exp_rd);
    end
    @(negedge clk);
    checks++;
    if (resp_valid2 !== 1'b1 || resp_error2 !== exp_err || resp_rdata2 !== exp_rd ||
        resp_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL %s lat2: got valid=%b err=%b rdata=%h lat1_valid=%b, want 1 %b %h lat1_valid=0",
               name, resp_valid2, resp_error2, resp_rdata2, resp_valid1, exp_err, exp_rd);
    end
  endtask

  task automatic test_reset();
    int f1, f2;
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (init_done1 !== 1'b0 || req_ready1 !== 1'b0 || resp_valid1 !== 1'b0 ||
        resp_error1 !== 1'b0 || resp_rdata1 !== 16'h0 || init_done2 !== 1'b0 ||
        req_ready2 !== 1'b0 || resp_valid2 !== 1'b0 || resp_rdata2 !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: got init=%b ready=%b valid=%b err=%b rdata=%h init2=%b valid2=%b, want all 0",
               init_done1, req_ready1, resp_valid1, resp_error1, resp_rdata1, init_done2,
               resp_valid2);
    end
    reset = 1'b0;
    wait_init(f1, f2);
    checks++;
    if (f1 != CLEAR_CYCLES || f2 != CLEAR_CYCLES || req_ready1 !== 1'b1 || req_ready2 !== 1'b1) begin
      failures++;
      $display("FAIL clear_time: got %0d/%0d cycles ready=%b/%b, want %0d cycles ready=1",
               f1, f2, req_ready1, req_ready2, CLEAR_CYCLES);
    end
    model_clear();
    xact("load_after_clear", 1'b0, 2'd1, 1'b0, 'h10, 16'h0);
  endtask

  task automatic test_store_load();
    xact("store_beef", 1'b1, 2'd1, 1'b0, 5, 16'hBEEF);
    xact("load_half_5", 1'b0, 2'd1, 1'b0, 5, 16'h0);
    xact("load_byte_6_u", 1'b0, 2'd0, 1'b0, 6, 16'h0);
    xact("load_byte_6_s", 1'b0, 2'd0, 1'b1, 6, 16'h0);
    xact("load_byte_5_s", 1'b0, 2'd0, 1'b1, 5, 16'h0);
  endtask

  task automatic test_range_errors();
    xact("store_byte_255", 1'b1, 2'd0, 1'b0, 255, 16'h005A);
    xact("store_half_255_err", 1'b1, 2'd1, 1'b0, 255, 16'h1234);
    xact("load_byte_255", 1'b0, 2'd0, 1'b0, 255, 16'h0);
    xact("load_word_err", 1'b0, 2'd2, 1'b0, 0, 16'h0);
    xact("load_dword_err", 1'b0, 2'd3, 1'b1, 8, 16'h0);
    xact("store_half_254", 1'b1, 2'd1, 1'b0, 254, 16'hA5C3);
    xact("load_byte_255_s", 1'b0, 2'd0, 1'b1, 255, 16'h0);
  endtask

  task automatic test_back_to_back();
    logic        e [3];
    logic [15:0] d [3];
    xact("pre_0", 1'b1, 2'd1, 1'b0, 0, 16'h1111);
    xact("pre_2", 1'b1, 2'd1, 1'b0, 2, 16'h2222);
    xact("pre_4", 1'b1, 2'd1, 1'b0, 4, 16'h3333);
    for (int i = 0; i < 3; i++) model_access(1'b0, 2'd1, 1'b0, 2 * i, 16'h0, e[i], d[i]);
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 16'(2 * c);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (c < 3) begin
        if (resp_valid1 !== 1'b1 || resp_error1 !== e[c] || resp_rdata1 !== d[c]) begin
          failures++;
          $display("FAIL b2b_lat1_%0d: got valid=%b err=%b rdata=%h, want 1 %b %h",
                   c, resp_valid1, resp_error1, resp_rdata1, e[c], d[c]);
        end
      end else if (resp_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL b2b_lat1_idle_%0d: got valid=%b, want 0", c, resp_valid1);
      end
      checks++;
      if (c >= 1 && c <= 3) begin
        if (resp_valid2 !== 1'b1 || resp_error2 !== e[c-1] || resp_rdata2 !== d[c-1]) begin
          failures++;
          $display("FAIL b2b_lat2_%0d: got valid=%b err=%b rdata=%h, want 1 %b %h",
                   c - 1, resp_valid2, resp_error2, resp_rdata2, e[c-1], d[c-1]);
        end
      end else if (resp_valid2 !== 1'b0) begin
        failures++;
        $display("FAIL b2b_lat2_idle_%0d: got valid=%b, want 0", c, resp_valid2);
      end
    end
  endtask

  task automatic test_random();
    logic        ev [NRAND+2];
    logic        ee [NRAND+2];
    logic [15:0] ed [NRAND+2];
    logic        w, sg, err;
    logic [1:0]  sz;
    logic [15:0] wd, rd;
    int          addr, r;
    for (int i = 0; i < NRAND + 2; i++) begin
      if (i >= 1) begin
        checks++;
        if (resp_valid1 !== ev[i-1] ||
            (ev[i-1] && (resp_error1 !== ee[i-1] || resp_rdata1 !== ed[i-1]))) begin
          failures++;
          $display("FAIL rand_lat1_%0d: got valid=%b err=%b rdata=%h, want %b %b %h",
                   i - 1, resp_valid1, resp_error1, resp_rdata1, ev[i-1], ee[i-1], ed[i-1]);
        end
      end
      if (i >= 2) begin
        checks++;
        if (resp_valid2 !== ev[i-2] ||
            (ev[i-2] && (resp_error2 !== ee[i-2] || resp_rdata2 !== ed[i-2]))) begin
          failures++;
          $display("FAIL rand_lat2_%0d: got valid=%b err=%b rdata=%h, want %b %b %h",
                   i - 2, resp_valid2, resp_error2, resp_rdata2, ev[i-2], ee[i-2], ed[i-2]);
        end
      end
      if (i < NRAND && $urandom_range(0, 3) != 0) begin
        w    = 1'($urandom_range(0, 1));
        sg   = 1'($urandom_range(0, 1));
        r    = int'($urandom_range(0, 9));
        sz   = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
        addr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(248, 255))
                                           : int'($urandom_range(0, 24));
        wd   = 16'($urandom);
        model_access(w, sz, sg, addr, wd, err, rd);
        ev[i] = 1'b1; ee[i] = err; ed[i] = rd;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = 16'(addr); req_wdata = wd;
      end else begin
        ev[i] = 1'b0; ee[i] = 1'b0; ed[i] = 16'h0;
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int f1, f2;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (init_done1 !== 1'b0 || init_done2 !== 1'b0 || req_ready1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_clear_busy: got init=%b/%b ready=%b, want 0", init_done1, init_done2,
               req_ready1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_init(f1, f2);
    checks++;
    if (f1 != CLEAR_CYCLES || f2 != CLEAR_CYCLES) begin
      failures++;
      $display("FAIL mid_clear_restart: got %0d/%0d cycles, want %0d", f1, f2, CLEAR_CYCLES);
    end
    model_clear();
    xact("load_after_restart", 1'b0, 2'd1, 1'b0, 0, 16'h0);
  endtask

  task automatic test_reset_inflight();
    int f1, f2;
    xact("store_cafe", 1'b1, 2'd1, 1'b0, 8, 16'hCAFE);
    xact("load_cafe", 1'b0, 2'd1, 1'b0, 8, 16'h0);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd1; req_signed = 1'b0; req_addr = 16'd8;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid2 !== 1'b0 || resp_valid1 !== 1'b0 || resp_rdata2 !== 16'h0) begin
        failures++;
        $display("FAIL inflight_drop_%0d: got valid=%b/%b rdata2=%h, want 0/0 0000",
                 c, resp_valid1, resp_valid2, resp_rdata2);
      end
    end
    reset = 1'b0;
    wait_init(f1, f2);
    checks++;
    if (f1 != CLEAR_CYCLES || f2 != CLEAR_CYCLES) begin
      failures++;
      $display("FAIL inflight_clear: got %0d/%0d cycles, want %0d", f1, f2, CLEAR_CYCLES);
    end
    model_clear();
    xact("load_cleared_8", 1'b0, 2'd1, 1'b0, 8, 16'h0);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_range_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
